fsmc_slave_router: RTL
======================

Name: fsmc_slave_router

Overview:
- Sits between fsmc_interface and up to 8 register-mapped peripheral slaves.
- Turns the interface's en_cs / module_in / cs_addr_latch transaction view into per-slave, single-cycle read and write strobes.
- Returns the selected slave's read data on module_out and drives cs_state back to the interface.
- Fills unmapped slots and unanswered reads with a fixed pattern, and counts them as errors.

Parameters:
- NUM_SLAVES, 4, number of attached slaves (1..8); slot index = cs_addr_latch.
- OFFS_W, 8, register offset width taken from module_in[OFFS_W-1:0] at address phase.
- TIMEOUT, 16, cycles to wait for rd_ack before substituting ERR_PAT (>=2).
- ERR_PAT, 16'hDEAD, read data returned on timeout or unmapped slot.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en_cs  in  1  transaction-active level from fsmc_interface.
- module_in  in  16  address (at en_cs rise) / write data (at en_cs fall) from fsmc_interface.
- cs_addr_latch  in  3  slot select from fsmc_interface.
- noe_n  in  1  raw FSMC NOE pin; asynchronous, synchronised internally.
- module_out  out  16  read data to fsmc_interface.
- cs_state  out  1  1 = this router will drive read data for the current transaction.
- wr_stb  out  NUM_SLAVES  one-hot, 1-cycle write strobe.
- rd_stb  out  NUM_SLAVES  one-hot, 1-cycle read request.
- bus_addr  out  OFFS_W  latched register offset; valid from ACTIVE until IDLE.
- bus_wdata  out  16  write data; valid in the wr_stb cycle.
- rd_data  in  16*NUM_SLAVES  flattened slave read data; slot k = bits [16k+15:16k].
- rd_ack  in  NUM_SLAVES  slave k read data valid (1 cycle or level).
- err_cnt  out  8  saturating count of timeouts, unmapped accesses and error writes.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (while reset low; mid-transaction reset aborts without strobes):
  - module_out = 0, cs_state = 0, wr_stb = 0, rd_stb = 0, bus_addr = 0, bus_wdata = 0, err_cnt = 0.
  - State = IDLE; all internal sync flops = 1 (noe idle level); en_cs_d = 0.
- noe_n passes through a 2-FF synchroniser giving noe_s.
- en_cs is registered as en_cs_d:
  - rise = en_cs & ~en_cs_d.
  - fall = ~en_cs & en_cs_d.
- States: IDLE, ACTIVE, RD_WAIT, RD_HOLD, WR_PULSE.
- IDLE, on rise:
  - Latch slot = cs_addr_latch and bus_addr = module_in[OFFS_W-1:0].
  - Clear the rd_seen flag.
  - Next cycle: state = ACTIVE, cs_state = 1.
  - cs_state is 1 for unmapped slots too; the router always drives.
- ACTIVE:
  - noe_s = 0: set rd_seen.
    - Mapped slot: rd_stb[slot] = 1 for exactly 1 cycle, then state = RD_WAIT with timer = 0.
    - Unmapped slot (slot >= NUM_SLAVES): module_out = ERR_PAT, err_cnt + 1, state = RD_HOLD.
  - fall with rd_seen = 0 means a write:
    - Mapped slot: capture bus_wdata = module_in, state = WR_PULSE.
    - Unmapped slot: drop the write, err_cnt + 1, state = IDLE.
  - fall and noe_s = 0 in the same cycle: treat as a read that is already over. Go to IDLE with no rd_stb.
- RD_WAIT:
  - rd_ack[slot] = 1: module_out = rd_data[slot] the following cycle, state = RD_HOLD.
  - Timer reaches TIMEOUT-1 without ack: module_out = ERR_PAT, err_cnt + 1, state = RD_HOLD.
  - Ack arriving in the same cycle as the last timer cycle wins; no error is counted.
  - fall: abort, state = IDLE, no error counted, module_out unchanged.
- RD_HOLD:
  - module_out is held and further acks are ignored.
  - A second noe_s low pulse in the same transaction issues no new rd_stb.
  - fall: state = IDLE.
- WR_PULSE: wr_stb[slot] = 1 for exactly 1 cycle, state = IDLE.
- On every entry to IDLE: cs_state = 0 and rd_seen is cleared. bus_addr is held until the next rise.
- Latency, read (mapped): noe_s low to rd_stb = 1 cycle; rd_ack to module_out valid = 1 cycle.
- Latency, write: en_cs fall, registered as fall, to wr_stb = 1 cycle.
- err_cnt saturates at 8'hFF.
- At most one strobe bit in wr_stb | rd_stb is set in any cycle.
- A rise seen in any non-IDLE state is ignored; en_cs must fall first.

Test Plan:
- Write, slot 1, offset 0x12, data 0xA5A5, NOE idle → exactly one cycle of wr_stb = 4'b0010 with bus_addr = 0x12, bus_wdata = 0xA5A5; cs_state returns to 0; err_cnt = 0.
- Read, slot 2, offset 0x05; slave acks 3 cycles after rd_stb with 0x1234 → rd_stb = 4'b0100 for one pulse; module_out = 0x1234 one cycle after ack; cs_state = 1 until en_cs fall.
- Read, slot 0, no ack, TIMEOUT = 16 → module_out = 0xDEAD exactly 16 cycles after rd_stb; err_cnt = 1.
- Unmapped: slot 6 read, then slot 7 write → no strobes; read returns 0xDEAD; err_cnt = 2.
- Reset asserted in RD_WAIT, then released → all outputs 0; the next write to slot 3 produces one wr_stb = 4'b1000; no stale rd ack is used.
- Force 260 timeouts → err_cnt saturates at 0xFF and holds.

Source files
------------

// File: rtl/fsmc_slave_router.sv
// fsmc_slave_router
// Bridges the fsmc_interface transaction view (en_cs level, module_in
// address/data, cs_addr_latch slot) onto up to 8 register-mapped slaves.
// Each transaction turns into one single-cycle read or write strobe. Read
// data comes back through module_out, and cs_state tells the interface that
// this router is driving the read data.
//
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   en_cs             transaction-active level
//   module_in         address at en_cs rise, write data at en_cs fall
//   cs_addr_latch     slot select
//   noe_n             raw FSMC NOE pin (asynchronous)
//   module_out        read data to the interface
//   cs_state          1 while the router owns the current transaction
//   wr_stb / rd_stb   one-hot, single-cycle per-slave strobes
//   bus_addr          latched register offset
//   bus_wdata         write data, valid in the wr_stb cycle
//   rd_data / rd_ack  flattened slave read data and per-slave valid
//   err_cnt           saturating count of timeouts / unmapped accesses
//   busy              state machine not idle
module fsmc_slave_router #(
    parameter int          NUM_SLAVES = 4,
    parameter int          OFFS_W     = 8,
    parameter int          TIMEOUT    = 16,
    parameter logic [15:0] ERR_PAT    = 16'hDEAD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en_cs,
    input  logic [15:0]              module_in,
    input  logic [2:0]               cs_addr_latch,
    input  logic                     noe_n,
    output logic [15:0]              module_out,
    output logic                     cs_state,
    output logic [NUM_SLAVES-1:0]    wr_stb,
    output logic [NUM_SLAVES-1:0]    rd_stb,
    output logic [OFFS_W-1:0]        bus_addr,
    output logic [15:0]              bus_wdata,
    input  logic [16*NUM_SLAVES-1:0] rd_data,
    input  logic [NUM_SLAVES-1:0]    rd_ack,
    output logic [7:0]               err_cnt,
    output logic                     busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_RD_WAIT,
        S_RD_HOLD,
        S_WR_PULSE
    } state_t;

    localparam int            TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    NS     = 4'(NUM_SLAVES);

    state_t              state_q, state_d;
    logic [2:0]          slot_q, slot_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                rd_seen_q, rd_seen_d;
    logic [15:0]         module_out_q, module_out_d;
    logic                cs_state_q, cs_state_d;
    logic [NUM_SLAVES-1:0] wr_stb_q, wr_stb_d;
    logic [NUM_SLAVES-1:0] rd_stb_q, rd_stb_d;
    logic [OFFS_W-1:0]   bus_addr_q, bus_addr_d;
    logic [15:0]         bus_wdata_q, bus_wdata_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                err_inc;

    logic noe_s1_q, noe_s_q;
    logic en_cs_d_q;
    logic rise, fall;

    // Slot index is always 3 bits; pad the slave-side vectors out to 8 slots
    // so unmapped slot numbers index zeros instead of running off the end.
    logic [7:0]       ack_pad;
    logic [7:0][15:0] data_pad;
    logic [7:0]       slot_oh;
    logic             mapped;

    for (genvar k = 0; k < 8; k++) begin : g_pad
        if (k < NUM_SLAVES) begin : g_on
            assign ack_pad[k]  = rd_ack[k];
            assign data_pad[k] = rd_data[16*k +: 16];
        end else begin : g_off
            assign ack_pad[k]  = 1'b0;
            assign data_pad[k] = 16'h0000;
        end
    end

    assign rise    = en_cs & ~en_cs_d_q;
    assign fall    = ~en_cs & en_cs_d_q;
    assign slot_oh = 8'd1 << slot_q;
    assign mapped  = ({1'b0, slot_q} < NS);

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        timer_d      = timer_q;
        rd_seen_d    = rd_seen_q;
        module_out_d = module_out_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        wr_stb_d     = '0;
        rd_stb_d     = '0;
        err_inc      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    slot_d     = cs_addr_latch;
                    bus_addr_d = module_in[OFFS_W-1:0];
                    rd_seen_d  = 1'b0;
                    state_d    = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (fall && !noe_s_q) begin
                    // NOE low and CS gone together: the read is already over.
                    state_d = S_IDLE;
                end else if (!noe_s_q) begin
                    rd_seen_d = 1'b1;
                    if (mapped) begin
                        rd_stb_d = slot_oh[NUM_SLAVES-1:0];
                        timer_d  = '0;
                        state_d  = S_RD_WAIT;
                    end else begin
                        module_out_d = ERR_PAT;
                        err_inc      = 1'b1;
                        state_d      = S_RD_HOLD;
                    end
                end else if (fall) begin
                    if (!rd_seen_q && mapped) begin
                        bus_wdata_d = module_in;
                        wr_stb_d    = slot_oh[NUM_SLAVES-1:0];
                        state_d     = S_WR_PULSE;
                    end else begin
                        err_inc = !rd_seen_q;
                        state_d = S_IDLE;
                    end
                end
            end
            S_RD_WAIT: begin
                if (fall) begin
                    state_d = S_IDLE;
                end else if (ack_pad[slot_q]) begin
                    // Ack beats the timeout even on the last timer cycle.
                    module_out_d = data_pad[slot_q];
                    state_d      = S_RD_HOLD;
                end else if (timer_q == T_LAST) begin
                    module_out_d = ERR_PAT;
                    err_inc      = 1'b1;
                    state_d      = S_RD_HOLD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RD_HOLD: begin
                if (fall) state_d = S_IDLE;
            end
            S_WR_PULSE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) rd_seen_d = 1'b0;
        cs_state_d = (state_d != S_IDLE);
        err_cnt_d  = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            slot_q       <= '0;
            timer_q      <= '0;
            rd_seen_q    <= 1'b0;
            module_out_q <= '0;
            cs_state_q   <= 1'b0;
            wr_stb_q     <= '0;
            rd_stb_q     <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            err_cnt_q    <= '0;
            noe_s1_q     <= 1'b1;
            noe_s_q      <= 1'b1;
            en_cs_d_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            timer_q      <= timer_d;
            rd_seen_q    <= rd_seen_d;
            module_out_q <= module_out_d;
            cs_state_q   <= cs_state_d;
            wr_stb_q     <= wr_stb_d;
            rd_stb_q     <= rd_stb_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            err_cnt_q    <= err_cnt_d;
            noe_s1_q     <= noe_n;
            noe_s_q      <= noe_s1_q;
            en_cs_d_q    <= en_cs;
        end
    end

    assign module_out = module_out_q;
    assign cs_state   = cs_state_q;
    assign wr_stb     = wr_stb_q;
    assign rd_stb     = rd_stb_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = (state_q != S_IDLE);

endmodule
